// File: rtl/qarma128_tk_sched.sv
// Iterative QARMA-128 forward tweakey generator.
// One {k0, tweak} job in, ROUNDS tweakey beats out: tk_i = k0 ^ T_i ^ RC[i],
// with the tweak advanced in place as T_{i+1} = omega(h(T_i)).

// One output cell of the tweak update: takes the h-selected source byte and
// optionally applies the omega LFSR step.
module qarma128_tk_cell #(
  parameter bit OMEGA = 1'b0
) (
  input  logic [7:0] s,
  output logic [7:0] c
);
  assign c = OMEGA ? {s[0] ^ s[2], s[7:1]} : s;
endmodule

module qarma128_tk_sched #(
  parameter int                      ROUNDS   = 8,
  parameter logic [128*ROUNDS-1:0]   RC_TABLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] k0,
  input  logic [127:0] tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] tk,
  output logic [3:0]   out_round,
  output logic         out_last
);
  localparam int       NUM_CELLS = 16;
  localparam logic [3:0] LAST    = 4'(ROUNDS - 1);

  // h: new cell j takes old cell HPERM[j]; index 0 is the leftmost entry.
  localparam logic [0:NUM_CELLS-1][3:0] HPERM = {
    4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
    4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11
  };
  // omega applies to cells 0,1,3,4,8,11,13.
  localparam logic [0:NUM_CELLS-1] OMASK = 16'b1101_1000_1001_0100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, t_q, tk_q, t_upd;
  logic [3:0]   cnt_q, cnt_nxt;
  logic         accept, beat, last;

  function automatic logic [127:0] rc_of(input logic [3:0] i);
    if (int'(i) >= ROUNDS) return '0;
    return RC_TABLE[128*i +: 128];
  endfunction

  // Tweak update network: one cell instance per byte lane.
  for (genvar j = 0; j < NUM_CELLS; j++) begin : g_cell
    qarma128_tk_cell #(.OMEGA(OMASK[j])) u_cell (
      .s (t_q[127 - 8*int'(HPERM[j]) -: 8]),
      .c (t_upd[127 - 8*j -: 8])
    );
  end

  assign last    = (cnt_q == LAST);
  assign accept  = (state_q == IDLE) && in_valid;
  assign beat    = (state_q == RUN) && out_ready;
  assign cnt_nxt = cnt_q + 4'd1;

  // Next-state and handshake outputs; the job ends on the beat carrying round ROUNDS-1.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Key/tweak/counter and registered tweakey; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      t_q   <= '0;
      cnt_q <= '0;
      tk_q  <= '0;
    end else if (accept) begin
      key_q <= k0;
      t_q   <= tweak;
      cnt_q <= '0;
      tk_q  <= k0 ^ tweak ^ rc_of(4'd0);
    end else if (beat && !last) begin
      t_q   <= t_upd;
      cnt_q <= cnt_nxt;
      tk_q  <= key_q ^ t_upd ^ rc_of(cnt_nxt);
    end
  end

  assign tk        = tk_q;
  assign out_round = cnt_q;
  assign out_last  = (state_q == RUN) && last;
endmodule

// File: tb/tb_qarma128_tk_sched.sv
// Directed bench for qarma128_tk_sched: reset, zero job, hand-traced tweak
// propagation, random stalls, back-to-back jobs and mid-job reset.
module tb_qarma128_tk_sched;
  localparam int ROUNDS = 8;
  // RC[i] = byte (i+1)*0x11 replicated; RC[0] in the LSB slice.
  localparam logic [128*ROUNDS-1:0] RCT = {
    {16{8'h88}}, {16{8'h77}}, {16{8'h66}}, {16{8'h55}},
    {16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}
  };

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [127:0] k0, tweak, tk;
  logic [3:0]   out_round;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qarma128_tk_sched #(.ROUNDS(ROUNDS), .RC_TABLE(RCT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .k0(k0), .tweak(tweak), .out_valid(out_valid), .out_ready(out_ready),
    .tk(tk), .out_round(out_round), .out_last(out_last)
  );

  function automatic logic [127:0] rc(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return {16{b}};
  endfunction

  // Reference tweak update written from the cell tables.
  function automatic logic [127:0] tw_upd(input logic [127:0] t);
    int hs[16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
    bit om[16] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    logic [7:0] c[16];
    logic [7:0] b;
    logic [127:0] r;
    for (int j = 0; j < 16; j++) c[j] = t[127 - 8*j -: 8];
    for (int j = 0; j < 16; j++) begin
      b = c[hs[j]];
      if (om[j]) b = {b[0] ^ b[2], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
      r[127 - 8*j -: 8] = b;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; k0 = '0; tweak = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (tk !== '0) begin n_fail++; $display("FAIL reset_tk got %h exp 0", tk); end
    n_chk++; if (out_round !== 4'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_round got %0d/%b exp 0/0", out_round, out_last); end
  endtask

  task automatic test_zero_job();
    k0 = '0; tweak = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < ROUNDS; i++) begin
      n_chk++; if (out_valid !== 1'b1 || out_round !== 4'(i)) begin n_fail++; $display("FAIL zero_beat%0d valid/round got %b/%0d exp 1/%0d", i, out_valid, out_round, i); end
      n_chk++; if (tk !== rc(i)) begin n_fail++; $display("FAIL zero_tk%0d got %h exp %h", i, tk, rc(i)); end
      n_chk++; if (out_last !== (i == ROUNDS - 1)) begin n_fail++; $display("FAIL zero_last%0d got %b", i, out_last); end
      @(negedge clk);
    end
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_end got valid %b ready %b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_single_cell();
    logic [127:0] exp_tk [3];
    int guard;
    exp_tk[0] = (128'h01 << 120) ^ rc(0);
    exp_tk[1] = (128'h80 << 88) ^ rc(1);   // cell0 -> cell4, omega 01->80
    exp_tk[2] = (128'h40 << 32) ^ rc(2);   // cell4 -> cell11, omega 80->40
    k0 = '0; tweak = 128'h01 << 120; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (tk !== exp_tk[i] || out_round !== 4'(i)) begin n_fail++; $display("FAIL cell_tk%0d got %h r%0d exp %h", i, tk, out_round, exp_tk[i]); end
      @(negedge clk);
    end
    guard = 0;
    while (out_valid && guard < 20) begin @(negedge clk); guard++; end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cell_drain timeout valid %b", out_valid); end
  endtask

  task automatic test_stall_random();
    logic [127:0] kk, tt, prev_tk;
    logic [3:0]   prev_round;
    int beats, cyc;
    bit stalled;
    kk = {$urandom, $urandom, $urandom, $urandom};
    tt = {$urandom, $urandom, $urandom, $urandom};
    k0 = kk; tweak = tt; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    beats = 0; cyc = 0; stalled = 1'b0; prev_tk = '0; prev_round = '0;
    while (beats < ROUNDS && cyc < 200) begin
      n_chk++; if (out_valid !== 1'b1 || out_round !== 4'(beats) || tk !== (kk ^ tt ^ rc(beats))) begin
        n_fail++; $display("FAIL rand_beat%0d got v%b r%0d tk %h exp tk %h", beats, out_valid, out_round, tk, kk ^ tt ^ rc(beats));
      end
      n_chk++; if (out_last !== (beats == ROUNDS - 1)) begin n_fail++; $display("FAIL rand_last%0d got %b", beats, out_last); end
      if (stalled) begin
        n_chk++; if (tk !== prev_tk || out_round !== prev_round) begin n_fail++; $display("FAIL rand_stall_hold got %h r%0d exp %h r%0d", tk, out_round, prev_tk, prev_round); end
      end
      prev_tk = tk; prev_round = out_round;
      out_ready = 1'($urandom_range(0, 1));
      stalled = !out_ready;
      if (out_ready) begin beats++; tt = tw_upd(tt); end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_chk++; if (beats != ROUNDS || out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_count beats %0d valid %b exp %0d/0", beats, out_valid, ROUNDS); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] kk;
    int ph;
    kk = 128'h0f0e0d0c0b0a09080706050403020100;
    k0 = kk; tweak = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 2 * (ROUNDS + 1); cyc++) begin
      ph = cyc % (ROUNDS + 1);
      if (ph < ROUNDS) begin
        n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_round !== 4'(ph)) begin
          n_fail++; $display("FAIL b2b_run c%0d got v%b rdy%b r%0d exp 1/0/%0d", cyc, out_valid, in_ready, out_round, ph);
        end
        if (ph == 0) begin
          n_chk++; if (tk !== (kk ^ rc(0))) begin n_fail++; $display("FAIL b2b_tk0 got %h exp %h", tk, kk ^ rc(0)); end
        end
      end else begin
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle c%0d got v%b rdy%b exp 0/1", cyc, out_valid, in_ready); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (ROUNDS) @(negedge clk);
  endtask

  task automatic test_reset_midjob();
    k0 = 128'h1234; tweak = 128'h01 << 120; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (out_round !== 4'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got r%0d v%b exp 3/1", out_round, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || tk !== '0 || out_round !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset got v%b rdy%b r%0d tk %h exp 0/1/0/0", out_valid, in_ready, out_round, tk);
    end
    k0 = '0; tweak = 128'h02 << 120; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (out_round !== 4'd0 || tk !== ((128'h02 << 120) ^ rc(0))) begin n_fail++; $display("FAIL mid_new0 got r%0d tk %h", out_round, tk); end
    @(negedge clk);
    // cell0 0x02 moves to cell4, omega 02->01
    n_chk++; if (out_round !== 4'd1 || tk !== ((128'h01 << 88) ^ rc(1))) begin n_fail++; $display("FAIL mid_new1 got r%0d tk %h", out_round, tk); end
    repeat (ROUNDS) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_job();
    test_single_cell();
    test_stall_random();
    test_back_to_back();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
